// File: rtl/mac_stop_matmul_engine_pkg.sv
// Shared definitions for the stoppable matrix-multiply engine.
//   state_t : controller states (IDLE, RUN, DRAIN, DONE)
//   addr_w  : address width for a dimension, never below one bit
package mac_stop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int addr_w(input int x);
        return ($clog2(x) > 1) ? $clog2(x) : 1;
    endfunction

endpackage

// File: rtl/mac_stop_matmul_engine_if.sv
// Bus between the engine and its surroundings (control, operand memories,
// result memory, status).
//   master : control inputs and memory read data driven toward the engine
//   slave  : the engine side; drives addresses, enables, results and status
interface mac_stop_matmul_engine_if
    import mac_stop_pkg::*;
#(
    parameter int M = 2,
    parameter int K = 2,
    parameter int N = 2,
    parameter int W = 32,
    parameter int R = 2 * W + $clog2(K)
) ();

    localparam int AW_M = addr_w(M);
    localparam int AW_K = addr_w(K);
    localparam int AW_N = addr_w(N);

    logic            start;
    logic            do_mac;
    logic            abort;
    logic [W-1:0]    data_in_a;
    logic [W-1:0]    data_in_b;
    logic [AW_M-1:0] row_addr_a;
    logic [AW_K-1:0] col_addr_a;
    logic [AW_K-1:0] row_addr_b;
    logic [AW_N-1:0] col_addr_b;
    logic            matrix_a_re;
    logic            matrix_b_re;
    logic            result_we;
    logic [AW_M-1:0] result_row_addr;
    logic [AW_N-1:0] result_col_addr;
    logic [R-1:0]    result_data;
    logic            busy;
    logic            mac_done;

    modport master (
        output start, do_mac, abort, data_in_a, data_in_b,
        input  row_addr_a, col_addr_a, row_addr_b, col_addr_b,
        input  matrix_a_re, matrix_b_re,
        input  result_we, result_row_addr, result_col_addr, result_data,
        input  busy, mac_done
    );

    modport slave (
        input  start, do_mac, abort, data_in_a, data_in_b,
        output row_addr_a, col_addr_a, row_addr_b, col_addr_b,
        output matrix_a_re, matrix_b_re,
        output result_we, result_row_addr, result_col_addr, result_data,
        output busy, mac_done
    );

endinterface

// File: rtl/mac_stop_matmul_engine_pe.sv
// Multiply-accumulate element: registered product followed by an
// accumulator that either loads (first term of a dot product) or adds.
//   clk, resetn : clock, asynchronous active-low reset
//   en          : advance enable; low freezes both registers
//   acc_en      : a valid product is present in the product register
//   load        : that product is the first term, so replace instead of add
//   a, b        : operands (W bits)
//   acc         : accumulator (R bits)
module mac_stop_pe #(
    parameter int W           = 32,
    parameter int R           = 2 * W + 1,
    parameter int SIGNED_MODE = 0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    input  logic         acc_en,
    input  logic         load,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [R-1:0] acc
);

    localparam bit SX = (SIGNED_MODE != 0);

    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    logic [2*W-1:0] prod_d;
    logic [2*W-1:0] prod_q;
    logic [R-1:0]   prod_r;
    logic [R-1:0]   acc_q;

    // Extending both operands to 2W before multiplying makes the low 2W
    // bits of the product correct for both signed and unsigned operands.
    always_comb begin
        a_ext  = {{W{SX && a[W-1]}}, a};
        b_ext  = {{W{SX && b[W-1]}}, b};
        prod_d = a_ext * b_ext;
        prod_r = {{(R-2*W){SX && prod_q[2*W-1]}}, prod_q};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else if (en) begin
            prod_q <= prod_d;
            if (acc_en) begin
                acc_q <= load ? prod_r : acc_q + prod_r;
            end
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mac_stop_matmul_engine.sv
// Matrix-multiply engine C = A * B with a global stop (do_mac) that freezes
// the whole datapath. One (i,k,j) term is issued per cycle, k innermost;
// each C element is written once its K-th term has been accumulated.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : start/do_mac/abort controls, A/B read ports, C write
//                 port, busy and mac_done status
module mac_stop_matmul_engine
    import mac_stop_pkg::*;
#(
    parameter int M                        = 2,
    parameter int K                        = 2,
    parameter int N                        = 2,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K),
    parameter int SIGNED_MODE              = 0
) (
    input logic                    clk,
    input logic                    resetn,
    mac_stop_matmul_engine_if.slave bus
);

    localparam int W    = DATA_WIDTH_INIT_MATRIX;
    localparam int R    = DATA_WIDTH_RESULT_MATRIX;
    localparam int AW_M = addr_w(M);
    localparam int AW_K = addr_w(K);
    localparam int AW_N = addr_w(N);

    state_t          state_q;
    logic [AW_M-1:0] i_q;
    logic [AW_K-1:0] k_q;
    logic [AW_N-1:0] j_q;

    logic i_last, k_last, j_last;
    logic issue, last_issue;

    // Pipeline tags: stage 1 = operands on the read bus, stage 2 = product
    // registered, stage 3 = accumulator holds a finished C element.
    logic            v1, v2, v3;
    logic            first1, first2;
    logic            last1, last2;
    logic [AW_M-1:0] row1, row2, row3;
    logic [AW_N-1:0] col1, col2, col3;

    logic [R-1:0]    acc;

    assign i_last     = (i_q == AW_M'(M - 1));
    assign k_last     = (k_q == AW_K'(K - 1));
    assign j_last     = (j_q == AW_N'(N - 1));
    assign issue      = (state_q == RUN) && bus.do_mac && !bus.abort;
    assign last_issue = issue && i_last && j_last && k_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else if (bus.abort) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start) state_q <= RUN;
                RUN:     if (last_issue) state_q <= DRAIN;
                // Stages 1 and 2 empty with do_mac high: the last element
                // is being written this cycle.
                DRAIN:   if (bus.do_mac && !v1 && !v2) state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_q <= '0;
            k_q <= '0;
            j_q <= '0;
        end else if (bus.abort) begin
            i_q <= '0;
            k_q <= '0;
            j_q <= '0;
        end else if (issue) begin
            if (k_last) begin
                k_q <= '0;
                if (j_last) begin
                    j_q <= '0;
                    i_q <= i_last ? '0 : i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end else begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            first1 <= 1'b0; first2 <= 1'b0;
            last1 <= 1'b0; last2 <= 1'b0;
            row1 <= '0; row2 <= '0; row3 <= '0;
            col1 <= '0; col2 <= '0; col3 <= '0;
        end else if (bus.abort) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            first1 <= 1'b0; first2 <= 1'b0;
            last1 <= 1'b0; last2 <= 1'b0;
            row1 <= '0; row2 <= '0; row3 <= '0;
            col1 <= '0; col2 <= '0; col3 <= '0;
        end else if (bus.do_mac) begin
            v1     <= issue;
            first1 <= (k_q == '0);
            last1  <= k_last;
            row1   <= i_q;
            col1   <= j_q;
            v2     <= v1;
            first2 <= first1;
            last2  <= last1;
            row2   <= row1;
            col2   <= col1;
            v3     <= v2 && last2;
            row3   <= row2;
            col3   <= col2;
        end
    end

    mac_stop_pe #(
        .W(W),
        .R(R),
        .SIGNED_MODE(SIGNED_MODE)
    ) u_pe (
        .clk   (clk),
        .resetn(resetn),
        .en    (bus.do_mac),
        .acc_en(v2),
        .load  (first2),
        .a     (bus.data_in_a),
        .b     (bus.data_in_b),
        .acc   (acc)
    );

    assign bus.matrix_a_re     = issue;
    assign bus.matrix_b_re     = issue;
    assign bus.row_addr_a      = i_q;
    assign bus.col_addr_a      = k_q;
    assign bus.row_addr_b      = k_q;
    assign bus.col_addr_b      = j_q;
    assign bus.result_we       = v3 && bus.do_mac && !bus.abort;
    assign bus.result_row_addr = row3;
    assign bus.result_col_addr = col3;
    assign bus.result_data     = acc;
    assign bus.busy            = (state_q == RUN) || (state_q == DRAIN);
    assign bus.mac_done        = (state_q == DONE) && !bus.abort;

endmodule

// File: doc/mac_stop_matmul_engine.md
MAC_STOP_MATMUL_ENGINE -- requirements
Module: mac_stop_matmul_engine

Interface
REQ-001 SHALL have parameter M, default 2, meaning rows of A and C (M >= 2).
REQ-002 SHALL have parameter K, default 2, meaning columns of A and rows of B (K >= 2).
REQ-003 SHALL have parameter N, default 2, meaning columns of B and C (N >= 2).
REQ-004 SHALL have parameter DATA_WIDTH_INIT_MATRIX, default 32, meaning operand width W.
REQ-005 SHALL have parameter DATA_WIDTH_RESULT_MATRIX, default 2*W+$clog2(K), meaning accumulator and result width R.
REQ-006 SHALL have parameter SIGNED_MODE, default 0, meaning 0 for unsigned and 1 for two's-complement operands.
REQ-007 clk  in  1  single clock; all logic on posedge.
REQ-008 resetn  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  single-cycle request to begin C=A*B; honoured only in IDLE.
REQ-010 do_mac  in  1  advance enable; low = stop, freezing the whole datapath.
REQ-011 abort  in  1  synchronous cancel of the current operation.
REQ-012 data_in_a, data_in_b  in  W  read data, valid 1 cycle after the matching read enable.
REQ-013 row_addr_a / col_addr_a / row_addr_b / col_addr_b  out  $clog2(M)/$clog2(K)/$clog2(K)/$clog2(N)  read addresses.
REQ-014 matrix_a_re, matrix_b_re  out  1  read enables.
REQ-015 result_we  out  1  one-cycle write strobe for one C element.
REQ-016 result_row_addr / result_col_addr  out  $clog2(M)/$clog2(N)  C element address.
REQ-017 result_data  out  R  C element value.
REQ-018 busy  out  1  high in RUN and DRAIN.
REQ-019 mac_done  out  1  one-cycle completion pulse.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-021 IDLE->RUN SHALL occur on start; RUN->DRAIN after the last issue (i=M-1, j=N-1, k=K-1); DRAIN->DONE when the pipeline is empty; DONE->IDLE unconditionally after 1 cycle.
REQ-022 Issue order SHALL be k innermost, then j, then i, with wrap to 0 at K-1, N-1 and M-1.
REQ-023 In RUN with do_mac=1, the block SHALL issue one (i,k,j) per cycle, with matrix_a_re=matrix_b_re=1, A address (i,k) and B address (k,j).
REQ-024 Pipeline stages SHALL be: issue (cycle t) -> product register = a*b (end of t+1) -> accumulate (end of t+2) -> result_we with final sum (cycle t+3, for k=K-1 only).
REQ-025 On the k=0 product, the accumulator SHALL load the product rather than add it, so no clear cycle is needed between elements.
REQ-026 do_mac=0 SHALL force both read enables low and hold every counter, pipeline register and valid bit; the memories hold their read data while their read enable is low.
REQ-027 result_we SHALL be gated by do_mac, so no write occurs and no write is duplicated across a stall.
REQ-028 With do_mac held high, start to mac_done SHALL take M*N*K+4 cycles.
REQ-029 mac_done SHALL pulse in the cycle after the final result_we.
REQ-030 SIGNED_MODE=1: operands SHALL be sign-extended, the product SHALL be signed 2W bits, and the accumulator SHALL be sign-extended to R.
REQ-031 SIGNED_MODE=0: zero extension SHALL be used; R bits are sufficient, so no overflow is possible.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 start with do_mac=0 SHALL enter RUN but issue nothing until do_mac=1.
REQ-034 abort in RUN, DRAIN or DONE SHALL return the FSM to IDLE next cycle, clear all valid bits and counters, and suppress further result_we and mac_done.
REQ-035 abort SHALL take priority over start and do_mac in the same cycle.
REQ-036 The address outputs SHALL equal the issue counters at all times, and SHALL read 0 in IDLE.

Reset
REQ-037 resetn low SHALL immediately force state=IDLE and zero all counters, valid bits, product and accumulator registers.
REQ-038 resetn low SHALL force every output to 0.
REQ-039 Reset mid-operation SHALL discard the operation, with no mac_done afterwards.

Structure
REQ-040 Package mac_stop_pkg SHALL hold the state enum and an address-width function max(1,$clog2(x)).
REQ-041 One sub-module, mac_stop_pe, SHALL hold the multiply, product register, accumulator and SIGNED_MODE extension, with stall and load/accumulate controls.

Verification
REQ-042 2x2x2 unsigned, A=[[1,2],[3,4]], B=[[5,6],[7,8]], do_mac=1 -> writes C00=19, C01=22, C10=43, C11=50 in that order; mac_done 12 cycles after start.
REQ-043 Same stimulus with do_mac low for 3 cycles after the 3rd issue -> identical C values, exactly 4 result_we, mac_done 15 cycles after start.
REQ-044 SIGNED_MODE=1, A=[[-1,2],[3,-4]], B=[[5,-6],[-7,8]] -> C=[[-19,22],[43,-50]] at R bits, sign-correct.
REQ-045 K=3, W=32, all operands 0xFFFFFFFF unsigned -> each C element = 3*(2^32-1)^2, with no truncation in R=66 bits.
REQ-046 abort asserted in DRAIN after 2 writes -> no further result_we, no mac_done, busy low next cycle; a following start completes normally.
REQ-047 start pulsed again mid-RUN, and resetn pulsed mid-RUN -> the second start has no effect; after reset all outputs are 0 and there is no mac_done.
